// File: rtl/turbo_uart_pkg.sv
// Shared definitions for the turbo codeword UART transmitter.
package turbo_uart_pkg;

   localparam int unsigned CW_WIDTH    = 24;
   localparam int unsigned FRAME_BYTES = 3;
   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned BIT_IDX_W   = 3;
   localparam int unsigned BYTE_IDX_W  = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Byte 0 is the most significant byte of the codeword.
   function automatic logic [DATA_BITS-1:0] select_byte(
      input logic [CW_WIDTH-1:0]   cw,
      input logic [BYTE_IDX_W-1:0] idx
   );
      logic [DATA_BITS-1:0] b;
      case (idx)
         2'd0:    b = cw[23:16];
         2'd1:    b = cw[15:8];
         default: b = cw[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/turbo_uart_tx_baud_tick_gen.sv
// Bit-time counter: tick pulses on the last cycle of every bit time.
module baud_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = !clear && (cnt == LAST);

   // Restarting at every boundary keeps each bit exactly CLKS_PER_BIT long.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/turbo_uart_tx.sv
// Sends one 24-bit turbo codeword as three back-to-back 8N1 UART frames.
module turbo_uart_tx
   import turbo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cw_valid,
   input  logic [CW_WIDTH-1:0] cw_data,
   output logic                cw_ready,
   output logic                tx,
   output logic                busy,
   output logic                cw_done
);

   localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);
   localparam logic                  LAST_STOP = 1'(STOP_BITS - 1);

   logic [1:0]            state,    state_d;
   logic [CW_WIDTH-1:0]   shadow,   shadow_d;
   logic [BIT_IDX_W-1:0]  bit_idx,  bit_idx_d;
   logic [BYTE_IDX_W-1:0] byte_idx, byte_idx_d;
   logic                  stop_idx, stop_idx_d;
   logic                  done_d;
   logic                  tx_d;
   logic [DATA_BITS-1:0]  cur_byte;
   logic                  tick;
   logic                  baud_clear;

   // Holding the counter clear while idle also zeroes it on accept.
   assign baud_clear = (state == ST_IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .clear(baud_clear),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d    = state;
      shadow_d   = shadow;
      bit_idx_d  = bit_idx;
      byte_idx_d = byte_idx;
      stop_idx_d = stop_idx;
      done_d     = 1'b0;
      tx_d       = 1'b1;
      cur_byte   = select_byte(shadow, byte_idx);

      case (state)
         ST_IDLE: begin
            if (cw_valid && cw_ready) begin
               shadow_d   = cw_data;
               bit_idx_d  = '0;
               byte_idx_d = '0;
               stop_idx_d = 1'b0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (tick) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_d = cur_byte[bit_idx];
            if (tick) begin
               if (bit_idx == LAST_BIT) begin
                  bit_idx_d  = '0;
                  stop_idx_d = 1'b0;
                  state_d    = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx + BIT_IDX_W'(1);
               end
            end
         end
         default: begin
            if (tick) begin
               if (stop_idx != LAST_STOP) begin
                  stop_idx_d = 1'b1;
               end else if (byte_idx != LAST_BYTE) begin
                  byte_idx_d = byte_idx + BYTE_IDX_W'(1);
                  state_d    = ST_START;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   // Line level is one cycle behind the FSM so tx comes straight off a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow   <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
         cw_ready <= 1'b1;
         busy     <= 1'b0;
         cw_done  <= 1'b0;
      end else begin
         shadow   <= shadow_d;
         bit_idx  <= bit_idx_d;
         byte_idx <= byte_idx_d;
         stop_idx <= stop_idx_d;
         tx       <= tx_d;
         cw_ready <= (state_d == ST_IDLE);
         busy     <= (state_d != ST_IDLE);
         cw_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_turbo_uart_tx.sv
// Scoreboard bench: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stops) decoded cycle by cycle.
module tb_turbo_uart_tx;

   localparam int CPB_A  = 4;
   localparam int STOP_A = 1;
   localparam int CPB_B  = 3;
   localparam int STOP_B = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_a, valid_b;
   logic [23:0] data_a, data_b;
   logic        ready_a, ready_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int acc_a[$], acc_b[$], done_a_q[$], done_b_q[$];

   always #5 clk = ~clk;

   turbo_uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(STOP_A)) u_dut_a (
      .clk(clk), .reset(reset), .cw_valid(valid_a), .cw_data(data_a),
      .cw_ready(ready_a), .tx(tx_a), .busy(busy_a), .cw_done(done_a)
   );

   turbo_uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(STOP_B)) u_dut_b (
      .clk(clk), .reset(reset), .cw_valid(valid_b), .cw_data(data_b),
      .cw_ready(ready_b), .tx(tx_b), .busy(busy_b), .cw_done(done_b)
   );

   // Edge numbering: accepts logged with the edge that takes them.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset && valid_a && ready_a) acc_a.push_back(cyc);
      if (!reset && valid_b && ready_b) acc_b.push_back(cyc);
   end

   always @(negedge clk) begin
      if (done_a) done_a_q.push_back(cyc);
      if (done_b) done_b_q.push_back(cyc);
   end

   task automatic push_word(input logic [23:0] w);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Finds a start bit, then checks every cycle of every bit against the popped byte.
   task automatic check_frame(input logic sel, input int cpb, input int stops,
                              input string tag, output int start_cyc);
      logic [7:0] b;
      logic       expv, gotv, bad, found;
      found = 1'b0;
      start_cyc = -1;
      for (int t = 0; t < 400 && !found; t++) begin
         @(negedge clk);
         if ((sel ? tx_b : tx_a) === 1'b0) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL %s start: got no start bit in 400 cycles, required one", tag);
         return;
      end
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s scoreboard: got unexpected frame at cycle %0d, required none", tag, cyc);
         return;
      end
      b = exp_q.pop_front();
      for (int j = 0; j < 9 + stops; j++) begin
         expv = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1;
         bad  = 1'b0;
         gotv = expv;
         for (int c = 0; c < cpb; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if ((sel ? tx_b : tx_a) !== expv) begin
               bad  = 1'b1;
               gotv = sel ? tx_b : tx_a;
            end
         end
         tests++;
         if (bad) begin
            fails++;
            $display("FAIL %s byte %h bit slot %0d: got %b, required %b for %0d cycles",
                     tag, b, j, gotv, expv, cpb);
         end
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      valid_a = 1'b0; data_a = '0;
      valid_b = 1'b0; data_b = '0;
      repeat (5) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      tests += 8;
      if (tx_a !== 1'b1)    begin fails++; $display("FAIL reset tx_a: got %b required 1", tx_a); end
      if (ready_a !== 1'b1) begin fails++; $display("FAIL reset ready_a: got %b required 1", ready_a); end
      if (busy_a !== 1'b0)  begin fails++; $display("FAIL reset busy_a: got %b required 0", busy_a); end
      if (done_a !== 1'b0)  begin fails++; $display("FAIL reset done_a: got %b required 0", done_a); end
      if (tx_b !== 1'b1)    begin fails++; $display("FAIL reset tx_b: got %b required 1", tx_b); end
      if (ready_b !== 1'b1) begin fails++; $display("FAIL reset ready_b: got %b required 1", ready_b); end
      if (busy_b !== 1'b0)  begin fails++; $display("FAIL reset busy_b: got %b required 0", busy_b); end
      if (done_b !== 1'b0)  begin fails++; $display("FAIL reset done_b: got %b required 0", done_b); end
   endtask

   task automatic test_single();
      int s[3];
      int na, nd, a0;
      na = acc_a.size();
      nd = done_a_q.size();
      @(negedge clk);
      valid_a = 1'b1; data_a = 24'hA53C0F;
      push_word(24'hA53C0F);
      @(negedge clk) valid_a = 1'b0;
      for (int i = 0; i < 3; i++) check_frame(1'b0, CPB_A, STOP_A, "single", s[i]);
      repeat (2) @(negedge clk);
      tests++;
      if (acc_a.size() != na + 1 || done_a_q.size() != nd + 1) begin
         fails++;
         $display("FAIL single counts: got %0d accepts %0d done pulses, required 1 and 1",
                  acc_a.size() - na, done_a_q.size() - nd);
         return;
      end
      a0 = acc_a[na];
      tests += 4;
      if (s[0] != a0 + 1) begin fails++; $display("FAIL single latency: got %0d required 1", s[0] - a0); end
      if (done_a_q[nd] - a0 != 3 * (9 + STOP_A) * CPB_A) begin
         fails++; $display("FAIL single duration: got %0d required %0d", done_a_q[nd] - a0, 3 * (9 + STOP_A) * CPB_A);
      end
      if (s[1] - s[0] != (9 + STOP_A) * CPB_A) begin fails++; $display("FAIL single gap01: got %0d required %0d", s[1] - s[0], (9 + STOP_A) * CPB_A); end
      if (s[2] - s[1] != (9 + STOP_A) * CPB_A) begin fails++; $display("FAIL single gap12: got %0d required %0d", s[2] - s[1], (9 + STOP_A) * CPB_A); end
   endtask

   task automatic test_back_to_back();
      int s[6];
      int na, nd;
      bit seen;
      na = acc_a.size();
      nd = done_a_q.size();
      @(negedge clk);
      valid_a = 1'b1; data_a = 24'h000000;
      push_word(24'h000000);
      fork
         begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               if (acc_a.size() > na) seen = 1'b1;
            end
            data_a = 24'hFFFFFF;
            push_word(24'hFFFFFF);
            seen = 1'b0;
            for (int t = 0; t < 400 && !seen; t++) begin
               @(negedge clk);
               if (acc_a.size() > na + 1) seen = 1'b1;
            end
            valid_a = 1'b0;
         end
         for (int i = 0; i < 6; i++) check_frame(1'b0, CPB_A, STOP_A, "b2b", s[i]);
      join
      repeat (2) @(negedge clk);
      tests++;
      if (acc_a.size() != na + 2 || done_a_q.size() != nd + 2) begin
         fails++;
         $display("FAIL b2b counts: got %0d accepts %0d done pulses, required 2 and 2",
                  acc_a.size() - na, done_a_q.size() - nd);
         return;
      end
      tests += 3;
      if (acc_a[na+1] != done_a_q[nd] + 1) begin
         fails++; $display("FAIL b2b accept: got edge %0d required %0d", acc_a[na+1], done_a_q[nd] + 1);
      end
      if (s[3] != acc_a[na+1] + 1) begin
         fails++; $display("FAIL b2b latency: got %0d required 1", s[3] - acc_a[na+1]);
      end
      if (s[3] - s[2] != (9 + STOP_A) * CPB_A + 1) begin
         fails++; $display("FAIL b2b idle gap: got %0d required 1", s[3] - s[2] - (9 + STOP_A) * CPB_A);
      end
   endtask

   task automatic test_stall();
      int s[3];
      int na, ready_hi;
      logic got_done, ready_at_done;
      na = acc_a.size();
      ready_hi = 0;
      got_done = 1'b0;
      ready_at_done = 1'b0;
      @(negedge clk);
      valid_a = 1'b1; data_a = 24'h3CA581;
      push_word(24'h3CA581);
      fork
         begin
            @(negedge clk) data_a = 24'h123456;
            for (int t = 0; t < 400 && !got_done; t++) begin
               @(negedge clk);
               if (done_a === 1'b1) begin
                  got_done = 1'b1;
                  ready_at_done = ready_a;
                  valid_a = 1'b0;
               end else if (ready_a !== 1'b0) begin
                  ready_hi++;
               end
            end
            valid_a = 1'b0;
         end
         for (int i = 0; i < 3; i++) check_frame(1'b0, CPB_A, STOP_A, "stall", s[i]);
      join
      repeat (2) @(negedge clk);
      tests += 4;
      if (ready_hi != 0) begin fails++; $display("FAIL stall ready: got %0d cycles high while busy, required 0", ready_hi); end
      if (got_done !== 1'b1) begin fails++; $display("FAIL stall done: got no cw_done, required one"); end
      if (ready_at_done !== 1'b1) begin fails++; $display("FAIL stall ready at done: got %b required 1", ready_at_done); end
      if (acc_a.size() != na + 1) begin fails++; $display("FAIL stall accepts: got %0d required 1", acc_a.size() - na); end
   endtask

   task automatic test_stop2();
      int s[3];
      int na, nd;
      na = acc_b.size();
      nd = done_b_q.size();
      @(negedge clk);
      valid_b = 1'b1; data_b = 24'h5A5A5A;
      push_word(24'h5A5A5A);
      @(negedge clk) valid_b = 1'b0;
      for (int i = 0; i < 3; i++) check_frame(1'b1, CPB_B, STOP_B, "stop2", s[i]);
      repeat (2) @(negedge clk);
      tests++;
      if (acc_b.size() != na + 1 || done_b_q.size() != nd + 1) begin
         fails++;
         $display("FAIL stop2 counts: got %0d accepts %0d done pulses, required 1 and 1",
                  acc_b.size() - na, done_b_q.size() - nd);
         return;
      end
      tests += 3;
      if (s[0] != acc_b[na] + 1) begin fails++; $display("FAIL stop2 latency: got %0d required 1", s[0] - acc_b[na]); end
      if (s[1] - s[0] != 33 || s[2] - s[1] != 33) begin
         fails++; $display("FAIL stop2 frame spacing: got %0d,%0d required 33,33", s[1] - s[0], s[2] - s[1]);
      end
      if (done_b_q[nd] - acc_b[na] != 99) begin
         fails++; $display("FAIL stop2 duration: got %0d required 99", done_b_q[nd] - acc_b[na]);
      end
   endtask

   task automatic test_reset_mid();
      int na, nd, a0, target, bad_line;
      na = acc_a.size();
      nd = done_a_q.size();
      @(negedge clk);
      valid_a = 1'b1; data_a = 24'hFF00FF;
      @(negedge clk) valid_a = 1'b0;
      tests++;
      if (acc_a.size() != na + 1) begin
         fails++; $display("FAIL rstmid accept: got %0d accepts required 1", acc_a.size() - na);
         return;
      end
      a0 = acc_a[na];
      // Byte 1, data bit 4 occupies line cycles a0+1+15*CPB .. a0+16*CPB.
      target = a0 + 1 + 15 * CPB_A + 1;
      for (int t = 0; t < 200 && cyc < target; t++) @(negedge clk);
      tests++;
      if (tx_a !== 1'b0) begin fails++; $display("FAIL rstmid pre: got tx %b required 0", tx_a); end
      #1 reset = 1'b1;
      #1;
      tests += 3;
      if (tx_a !== 1'b1)    begin fails++; $display("FAIL rstmid async tx: got %b required 1", tx_a); end
      if (busy_a !== 1'b0)  begin fails++; $display("FAIL rstmid async busy: got %b required 0", busy_a); end
      if (ready_a !== 1'b1) begin fails++; $display("FAIL rstmid async ready: got %b required 1", ready_a); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bad_line = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1) bad_line++;
      end
      tests += 2;
      if (bad_line != 0) begin fails++; $display("FAIL rstmid residual: got %0d non-idle cycles required 0", bad_line); end
      if (done_a_q.size() != nd) begin fails++; $display("FAIL rstmid done: got %0d pulses required 0", done_a_q.size() - nd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_stop2();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
